// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, FSM encoding and widths for nibble_alu_seq
package alu_pkg;
  localparam int W       = 16;
  localparam int NIBBLES = 4;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;
endpackage

// File: rtl/alu_slice4.sv
// rtl/alu_slice4.sv - combinational 4-bit carry-lookahead ALU slice
module alu_slice4
  import alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  input  logic [2:0] op,
  output logic [3:0] r,
  output logic       c_out,
  output logic       c3
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum of products of g/p/ci, no ripple chain.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  assign c_out = c[4];
  assign c3    = c[3];

  always_comb begin
    r = 4'h0;
    case (op)
      OP_AND:  r = g;
      OP_OR:   r = a | b;
      OP_ADD:  r = p ^ c[3:0];
      default: r = 4'h0;
    endcase
  end
endmodule

// File: rtl/nibble_alu_seq.sv
// rtl/nibble_alu_seq.sv - 16-bit ALU evaluated one nibble per cycle through a single 4-bit slice
module nibble_alu_seq
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [2:0]    op,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic          c_out,
  output logic          zero,
  output logic          overflow,
  output logic          illegal
);

  logic [1:0]   state;
  logic [1:0]   n;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [2:0]   op_q;
  logic         carry;
  logic [11:0]  acc;

  logic         inv;
  logic         arith;
  logic         legal;
  logic [3:0]   s_b;
  logic [2:0]   s_op;
  logic [3:0]   s_r;
  logic         s_cout;
  logic         s_c3;
  logic [W-1:0] full;
  logic         ovf;
  logic         lt;

  always_comb begin
    inv   = (op_q == OP_SUB) || (op_q == OP_SLT);
    arith = inv || (op_q == OP_ADD);
    legal = arith || (op_q == OP_AND) || (op_q == OP_OR);
    s_b   = b_q[3:0] ^ {4{inv}};
    s_op  = arith ? OP_ADD : op_q;
    full  = {s_r, acc};
    ovf   = s_c3 ^ s_cout;
    lt    = full[W-1] ^ ovf;
  end

  alu_slice4 u_slice (
    .a     (a_q[3:0]),
    .b     (s_b),
    .ci    (carry),
    .op    (s_op),
    .r     (s_r),
    .c_out (s_cout),
    .c3    (s_c3)
  );

  assign busy = (state != IDLE);

  // Operands shift right so the active nibble always sits in bits [3:0];
  // results enter acc from the top, leaving the low 12 bits in place after nibble 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      n        <= 2'd0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_AND;
      carry    <= 1'b0;
      acc      <= '0;
      done     <= 1'b0;
      result   <= '0;
      c_out    <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            n     <= 2'd0;
            carry <= (op == OP_SUB) || (op == OP_SLT);
            state <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_q >> 4;
          b_q   <= b_q >> 4;
          acc   <= {s_r, acc[11:4]};
          carry <= s_cout;
          n     <= n + 2'd1;
          if (n == 2'd3) begin
            state   <= FIN;
            done    <= 1'b1;
            illegal <= !legal;
            if (!legal) begin
              result   <= '0;
              zero     <= 1'b1;
              c_out    <= 1'b0;
              overflow <= 1'b0;
            end else if (op_q == OP_SLT) begin
              result   <= {{(W-1){1'b0}}, lt};
              zero     <= !lt;
              c_out    <= 1'b0;
              overflow <= 1'b0;
            end else begin
              result   <= full;
              zero     <= (full == '0);
              c_out    <= arith ? s_cout : 1'b0;
              overflow <= arith ? ovf : 1'b0;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_alu_seq.sv
// tb/tb_nibble_alu_seq.sv - self-checking bench for nibble_alu_seq against an arithmetic model
module tb_nibble_alu_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  op;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        c_out;
  logic        zero;
  logic        overflow;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  nibble_alu_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .op       (op),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .c_out    (c_out),
    .zero     (zero),
    .overflow (overflow),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                       output logic [15:0] r, output logic c, output logic z,
                       output logic v, output logic ill);
    logic [16:0] s;
    r = 16'h0; c = 1'b0; v = 1'b0; ill = 1'b0;
    case (o)
      3'b000: r = x & y;
      3'b001: r = x | y;
      3'b010: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[15:0]; c = s[16];
        v = (x[15] == y[15]) && (r[15] != x[15]);
      end
      3'b110: begin
        s = {1'b0, x} + {1'b0, ~y} + 17'd1;
        r = s[15:0]; c = s[16];
        v = (x[15] != y[15]) && (r[15] != x[15]);
      end
      3'b111: r = ($signed(x) < $signed(y)) ? 16'd1 : 16'd0;
      default: ill = 1'b1;
    endcase
    z = (r == 16'h0);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                        input bit poke);
    logic [15:0] er;
    logic ec, ez, ev, ei;
    int lat = 0;
    int ndone = 0;
    model(o, x, y, er, ec, ez, ev, ei);
    @(negedge clk);
    start = 1'b1; a = x; b = y; op = o;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start = 1'b0;
      a = 16'($urandom); b = 16'($urandom); op = 3'($urandom);
      if (poke && k == 2) start = 1'b1;
      if (k == 1) chk("busy_after_start", busy, 1);
      if (k == 6) chk("idle_after_done", busy, 0);
      if (done) begin
        ndone++;
        if (lat == 0) begin
          lat = k;
          chk("result", result, er);
          chk("c_out", c_out, ec);
          chk("zero", zero, ez);
          chk("overflow", overflow, ev);
          chk("illegal", illegal, ei);
        end
      end
    end
    start = 1'b0;
    chk("latency", lat, 5);
    chk("done_count", ndone, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0; op = 3'b000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_c_out", c_out, 0);
    chk("rst_zero", zero, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_illegal", illegal, 0);

    run_op(3'b010, 16'h00FF, 16'h0001, 0);
    run_op(3'b110, 16'h0000, 16'h0007, 0);
    run_op(3'b110, 16'h1234, 16'h1234, 0);
    run_op(3'b010, 16'h7FFF, 16'h0001, 0);
    run_op(3'b111, 16'h8000, 16'h0001, 0);
    run_op(3'b111, 16'h0005, 16'hFFFF, 0);
    run_op(3'b000, 16'hF0F0, 16'hFFFF, 0);
    run_op(3'b001, 16'h8000, 16'h0007, 0);
    run_op(3'b100, 16'h1234, 16'h5678, 0);
    run_op(3'b010, 16'hFFFF, 16'h0001, 0);
    run_op(3'b110, 16'h8000, 16'h0001, 0);
    run_op(3'b010, 16'h1111, 16'h2222, 1);

    // Reset in the middle of RUN must abort without a done pulse.
    @(negedge clk);
    start = 1'b1; a = 16'h0F0F; b = 16'h0101; op = 3'b010;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_result", result, 0);
    chk("abort_zero", zero, 0);
    begin
      int nd = 0;
      for (int k = 0; k < 8; k++) begin
        if (done) nd++;
        @(negedge clk);
      end
      chk("abort_no_done", nd, 0);
    end

    // Reset and start together: start must be dropped.
    start = 1'b1; reset = 1'b1;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    chk("rst_start_busy", busy, 0);

    run_op(3'b010, 16'h0F0F, 16'h0101, 0);

    for (int i = 0; i < 40; i++)
      run_op(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
